sub_serial_ctrl: RTL

- Bit-serial sequencer for the one-bit full-subtractor cell (inputs a, b, bi; outputs D, bo) in the ALU datapath.
- Latches two WIDTH-bit operands and feeds one bit pair per clock to an external cell instance, LSB first.
- Holds the inter-bit borrow in a flop, assembles the difference and reports completion with a start/busy/done handshake.
- The ALU top uses it as its area-reduced subtract path.

---
 rtl/sub_serial_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/sub_serial_ctrl.sv
// Bit-serial subtract sequencer driving an external one-bit full-subtractor cell, LSB first.
// Define SUB_SERIAL_OVF_EN to add the signed-overflow output v.
module sub_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_bi,
    input  logic             cell_d,
    input  logic             cell_bo
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             v
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, d_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] d_new;

`ifdef SUB_SERIAL_OVF_EN
    logic a_msb, b_msb;
`endif

    assign last  = (cnt == CW'(WIDTH - 1));
    assign d_new = {cell_d, d_sh[WIDTH-1:1]};
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cell_a    = 1'b0;
        cell_b    = 1'b0;
        cell_bi   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                cell_a  = a_sh[0];
                cell_b  = b_sh[0];
                cell_bi = brw;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The cell is combinational: its D/bo for the current bit are captured on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            d    <= '0;
            bout <= 1'b0;
`ifdef SUB_SERIAL_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            v     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= bin;
                        cnt  <= '0;
`ifdef SUB_SERIAL_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_new;
                    brw  <= cell_bo;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        d    <= d_new;
                        bout <= cell_bo;
`ifdef SUB_SERIAL_OVF_EN
                        v    <= (a_msb ^ b_msb) & (a_msb ^ d_new[WIDTH-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
